// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message sequencer.
package sha1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_FILL = 3'd2,
        ST_PAD  = 3'd3,
        ST_HASH = 3'd4,
        ST_DONE = 3'd5
    } sha1_ctrl_state_e;

    localparam int          BlockWords = 16;
    localparam logic [31:0] PadWord    = 32'h8000_0000;
    localparam int          LenWidth   = 64;

    // Byte counts above four on the last word mean a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/sha1_last_word.sv
// Final message word: keeps the first n bytes, zeroes the rest and places the
// 0x80 terminator right after the data when it fits in this word.
module sha1_last_word
    import sha1_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  bytes_i,
    output logic [31:0] word_o,
    output logic        pad_pending_o
);

    logic [2:0] n_s;

    // Byte 0 lives in [31:24]; a full word defers the terminator to the next word.
    always_comb begin
        n_s           = clamp_bytes(bytes_i);
        pad_pending_o = (n_s == 3'd4);
        word_o        = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < n_s) begin
                word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
            end else if (3'(b) == n_s) begin
                word_o[31-8*b -: 8] = 8'h80;
            end else begin
                word_o[31-8*b -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/sha1_ctrl.sv
// SHA-1 message sequencer: packs a word stream into 512-bit blocks, applies
// padding and length, drives the core handshake and returns the final digest.
module sha1_ctrl
    import sha1_pkg::*;
#(
    parameter int BlockWidth  = 512,
    parameter int DigestWidth = 160
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   msg_valid_i,
    output logic                   msg_ready_o,
    input  logic [31:0]            msg_data_i,
    input  logic                   msg_last_i,
    input  logic [2:0]             msg_bytes_i,
    output logic                   busy_o,
    output logic [BlockWidth-1:0]  block_o,
    output logic                   enable_hash_o,
    output logic                   rst_hash_o,
    input  logic                   hold_i,
    input  logic                   idle_i,
    input  logic [DigestWidth-1:0] digest_i,
    input  logic                   digest_valid_i,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   digest_valid_o,
    input  logic                   digest_ready_i
);

    sha1_ctrl_state_e state_q, state_d;
    logic [3:0]                        idx_q, idx_d;
    logic [LenWidth-1:0]               len_q, len_d;
    logic                              pad_pending_q, pad_pending_d;
    logic                              len_fits_q, len_fits_d;
    logic                              final_q, final_d;
    logic                              pad_started_q, pad_started_d;
    logic                              enable_sent_q, enable_sent_d;
    logic                              enable_q, enable_d;
    logic                              rst_hash_q, rst_hash_d;
    logic [BlockWords-1:0][31:0]       block_q, block_d;
    logic [DigestWidth-1:0]            digest_q, digest_d;

    logic        wr_en_s;
    logic [31:0] wr_word_s;
    logic [31:0] lw_word_s;
    logic        lw_pad_s;
    logic [2:0]  nb_s;

    sha1_last_word u_last_word (
        .data_i        (msg_data_i),
        .bytes_i       (msg_bytes_i),
        .word_o        (lw_word_s),
        .pad_pending_o (lw_pad_s)
    );

    assign nb_s           = clamp_bytes(msg_bytes_i);
    assign msg_ready_o    = (state_q == ST_FILL);
    assign busy_o         = (state_q != ST_IDLE);
    assign block_o        = block_q;
    assign enable_hash_o  = enable_q;
    assign rst_hash_o     = rst_hash_q;
    assign digest_o       = digest_q;
    assign digest_valid_o = (state_q == ST_DONE);

    // Next-state, block writes and handshake pulses.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        pad_pending_d = pad_pending_q;
        len_fits_d    = len_fits_q;
        final_d       = final_q;
        pad_started_d = pad_started_q;
        enable_sent_d = enable_sent_q;
        block_d       = block_q;
        digest_d      = digest_q;
        enable_d      = 1'b0;
        rst_hash_d    = 1'b0;
        wr_en_s       = 1'b0;
        wr_word_s     = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (msg_valid_i) begin
                    state_d    = ST_INIT;
                    rst_hash_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                idx_d         = 4'd0;
                len_d         = 64'd0;
                pad_pending_d = 1'b0;
                len_fits_d    = 1'b0;
                final_d       = 1'b0;
                pad_started_d = 1'b0;
                enable_sent_d = 1'b0;
                state_d       = ST_FILL;
            end
            ST_FILL: begin
                if (msg_valid_i) begin
                    wr_en_s = 1'b1;
                    idx_d   = idx_q + 4'd1;
                    if (msg_last_i) begin
                        wr_word_s     = lw_word_s;
                        len_d         = len_q + {58'd0, nb_s, 3'd0};
                        pad_started_d = 1'b1;
                        pad_pending_d = lw_pad_s;
                        if (lw_pad_s) begin
                            len_fits_d = len_fits_q;
                        end else begin
                            len_fits_d = (idx_q <= 4'd13);
                        end
                        state_d = (idx_q == 4'd15) ? ST_HASH : ST_PAD;
                    end else begin
                        wr_word_s = msg_data_i;
                        len_d     = len_q + 64'd32;
                        if (idx_q == 4'd15) begin
                            final_d = 1'b0;
                            state_d = ST_HASH;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_PAD: begin
                wr_en_s = 1'b1;
                idx_d   = idx_q + 4'd1;
                if (pad_pending_q) begin
                    wr_word_s     = PadWord;
                    pad_pending_d = 1'b0;
                    len_fits_d    = (idx_q <= 4'd13);
                end else if (len_fits_q && (idx_q == 4'd14)) begin
                    wr_word_s = len_q[63:32];
                end else if (len_fits_q && (idx_q == 4'd15)) begin
                    wr_word_s = len_q[31:0];
                    final_d   = 1'b1;
                end else begin
                    wr_word_s = 32'h0000_0000;
                end
                state_d = (idx_q == 4'd15) ? ST_HASH : ST_PAD;
            end
            ST_HASH: begin
                // One enable per block; the digest pulse is only honoured after it.
                if (!enable_sent_q) begin
                    if (idle_i && !hold_i) begin
                        enable_d      = 1'b1;
                        enable_sent_d = 1'b1;
                    end else begin
                        enable_d = 1'b0;
                    end
                end else if (digest_valid_i) begin
                    enable_sent_d = 1'b0;
                    if (final_q) begin
                        digest_d = digest_i;
                        state_d  = ST_DONE;
                    end else if (pad_started_q) begin
                        len_fits_d = 1'b1;
                        idx_d      = 4'd0;
                        state_d    = ST_PAD;
                    end else begin
                        idx_d   = 4'd0;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_HASH;
                end
            end
            ST_DONE: begin
                if (digest_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_en_s) begin
            block_d[4'd15 - idx_q] = wr_word_s;
        end else begin
            block_d = block_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            len_q         <= 64'd0;
            pad_pending_q <= 1'b0;
            len_fits_q    <= 1'b0;
            final_q       <= 1'b0;
            pad_started_q <= 1'b0;
            enable_sent_q <= 1'b0;
            enable_q      <= 1'b0;
            rst_hash_q    <= 1'b0;
            block_q       <= '0;
            digest_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            pad_pending_q <= pad_pending_d;
            len_fits_q    <= len_fits_d;
            final_q       <= final_d;
            pad_started_q <= pad_started_d;
            enable_sent_q <= enable_sent_d;
            enable_q      <= enable_d;
            rst_hash_q    <= rst_hash_d;
            block_q       <= block_d;
            digest_q      <= digest_d;
        end
    end

endmodule
